vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
- Transaction controller for the coin-operated vending datapath: accepts coins (values 1, 2, 5), tracks credit, takes a product selection against a parameterised price table, and drives item dispensing.
- Returns change or refunds one coin at a time through valid/ready handshakes.
- Sits between the coin acceptor / keypad front-end and the item and coin dispenser mechanisms.

Parameters:
- PRICE0, 5, price of product 0.
- PRICE1, 6, price of product 1.
- PRICE2, 7, price of product 2.
- PRICE3, 9, price of product 3.
- CREDIT_W, 5, credit register width; must hold MAX_CREDIT.
- MAX_CREDIT, 20, highest credit accepted; a coin that would exceed it is rejected.
- TIMEOUT, 200, idle cycles in COLLECT before an automatic refund.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle strobe: coin present.
- coin  in  3  coin value code: 3'b001 = 1, 3'b010 = 2, 3'b101 = 5; any other code is invalid.
- sel_valid  in  1  one-cycle strobe: product selected.
- sel  in  2  product index 0..3.
- cancel  in  1  one-cycle strobe: refund request.
- vend_ready  in  1  item dispenser accepts.
- chg_ready  in  1  coin dispenser accepts.
- vend_valid  out  1  item dispense request.
- vend_item  out  2  item index, held while vend_valid=1.
- chg_valid  out  1  change coin request.
- chg_coin  out  3  change coin code, same encoding as coin.
- credit  out  CREDIT_W  current credit.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- sel_short  out  1  one-cycle pulse: selection refused, credit below price.
- busy  out  1  state is VEND or CHANGE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, credit=0, timeout counter=0, all outputs 0.
- All outputs are registered. An accepted coin or selection becomes visible one cycle later.
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE:
  - A valid coin moves to COLLECT with credit = coin value.
  - sel_valid pulses sel_short.
  - cancel is ignored.
- COLLECT, priority cancel > sel_valid > coin_valid:
  - cancel: go to CHANGE; a coin in the same cycle is rejected.
  - sel_valid with credit >= PRICEsel: credit -= price, latch vend_item=sel, go to VEND. A coin in the same cycle is rejected.
  - sel_valid with credit < price: sel_short pulse, credit unchanged, state unchanged. A coin in the same cycle is still processed normally.
  - Valid coin with credit+value <= MAX_CREDIT: credit += value, timeout counter cleared.
  - Invalid code, or credit+value > MAX_CREDIT: coin_reject pulse, credit unchanged.
  - Timeout counter increments every cycle without an accepted coin. Reaching TIMEOUT goes to CHANGE (refund).
- VEND:
  - vend_valid=1 and vend_item stable until vend_ready=1 is sampled.
  - Handshake cycle: vend_valid drops next cycle; next state is CHANGE if credit>0, else IDLE.
  - cancel and sel are ignored.
- CHANGE (change and refund share this path):
  - Greedy coin selection: chg_coin = 5 if credit>=5, else 2 if credit>=2, else 1.
  - chg_valid=1 held until chg_ready=1 is sampled; then credit -= coin value.
  - When credit reaches 0, go to IDLE with chg_valid=0 next cycle. Otherwise present the next coin without a gap cycle.
  - cancel and sel are ignored.
- In VEND and CHANGE, every coin_valid produces coin_reject.
- Credit arithmetic is unsigned and never wraps or underflows; MAX_CREDIT bounds it.
- Reset asserted mid-VEND or mid-CHANGE aborts immediately; the pending item or change is lost by design.
- busy=1 exactly while in VEND or CHANGE.

Test Plan:
- Coins 1, 2, 5, then sel=0 (price 5).
  - credit reads 1, 3, 8; vend_valid=1 with vend_item=0.
  - After vend_ready: chg_coin 2 then 1; credit 3 -> 1 -> 0; IDLE; busy back to 0.
- Coin 5, sel=0, vend_ready held high.
  - vend_valid for one cycle; credit 0; no chg_valid; return to IDLE.
- Coins 2, 2, then sel=0.
  - sel_short pulse; credit stays 4.
  - cancel -> chg_coin 2, 2 with chg_ready toggling; each coin held until accepted.
- Four 5-coins, then a fifth 5, then coin code 3'b011.
  - credit=20; coin_reject on both the fifth coin and the invalid code; credit stays 20.
  - sel=3 -> vend item 3, change 11 paid as 5, 5, 1.
- Timeout and simultaneous events.
  - Coin 2, then TIMEOUT idle cycles -> chg_coin 2 auto-refund.
  - Separately: cancel and coin in the same cycle -> coin_reject, refund of the prior credit only.
- Reset mid-operation.
  - In CHANGE with chg_ready=0, assert rst=0 mid-cycle: all outputs 0 immediately, credit=0.
  - After release, a coin 1 is accepted normally.

Source files
------------

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl
// Purpose  : Vending transaction controller. Accepts coins (1, 2, 5), tracks
//            credit, checks a product selection against a price table, drives
//            the item dispenser and then pays change or a refund one coin at a
//            time, largest coin first.
// Ports    : clk, rst (async, active low)
//            coin_valid/coin      - coin acceptor strobe and value code
//            sel_valid/sel        - keypad selection strobe and product index
//            cancel               - refund request
//            vend_valid/vend_item/vend_ready - item dispenser handshake
//            chg_valid/chg_coin/chg_ready    - coin dispenser handshake
//            credit               - current credit
//            coin_reject/sel_short- one-cycle refusal pulses
//            busy                 - dispensing an item or paying coins
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl #(
   parameter int PRICE0     = 5,
   parameter int PRICE1     = 6,
   parameter int PRICE2     = 7,
   parameter int PRICE3     = 9,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20,
   parameter int TIMEOUT    = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [2:0]          coin,
   input  logic                sel_valid,
   input  logic [1:0]          sel,
   input  logic                cancel,
   input  logic                vend_ready,
   input  logic                chg_ready,
   output logic                vend_valid,
   output logic [1:0]          vend_item,
   output logic                chg_valid,
   output logic [2:0]          chg_coin,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                sel_short,
   output logic                busy
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   // Coin code to value; zero marks an invalid code.
   function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] c);
      case (c)
         3'b001:  return CREDIT_W'(1);
         3'b010:  return CREDIT_W'(2);
         3'b101:  return CREDIT_W'(5);
         default: return '0;
      endcase
   endfunction

   function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
      case (s)
         2'd0:    return CREDIT_W'(PRICE0);
         2'd1:    return CREDIT_W'(PRICE1);
         2'd2:    return CREDIT_W'(PRICE2);
         default: return CREDIT_W'(PRICE3);
      endcase
   endfunction

   // Largest coin not exceeding the remaining credit.
   function automatic logic [2:0] greedy_coin(input logic [CREDIT_W-1:0] cr);
      if (cr >= CREDIT_W'(5))      return 3'b101;
      else if (cr >= CREDIT_W'(2)) return 3'b010;
      else                         return 3'b001;
   endfunction

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [1:0]          vend_item_q, vend_item_d;
   logic                vend_valid_q, vend_valid_d;
   logic                chg_valid_q, chg_valid_d;
   logic [2:0]          chg_coin_q, chg_coin_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_short_q, sel_short_d;
   logic                busy_q, busy_d;

   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] sel_price;
   logic [2:0]          pay_coin;

   // One extra bit on the sum so an over-limit coin cannot wrap into range.
   assign coin_val  = coin_value(coin);
   assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_fits = (coin_val != '0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
   assign sel_price = price_of(sel);
   assign pay_coin  = greedy_coin(credit_q);

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      tmo_d         = '0;
      vend_item_d   = vend_item_q;
      coin_reject_d = 1'b0;
      sel_short_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            sel_short_d = sel_valid;
            if (coin_valid) begin
               if (coin_fits) begin
                  state_d  = S_COLLECT;
                  credit_d = coin_val;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (cancel) begin
               state_d       = S_CHANGE;
               coin_reject_d = coin_valid;
            end else if (sel_valid && (credit_q >= sel_price)) begin
               state_d       = S_VEND;
               credit_d      = credit_q - sel_price;
               vend_item_d   = sel;
               coin_reject_d = coin_valid;
            end else begin
               // A short selection still lets a same-cycle coin through.
               sel_short_d = sel_valid;
               if (coin_valid && coin_fits) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
               end else begin
                  coin_reject_d = coin_valid;
                  if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                     state_d = S_CHANGE;
                  end else begin
                     tmo_d = tmo_q + 1'b1;
                  end
               end
            end
         end
         S_VEND: begin
            coin_reject_d = coin_valid;
            if (vend_ready) begin
               state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
         end
         S_CHANGE: begin
            coin_reject_d = coin_valid;
            if (chg_ready) begin
               credit_d = credit_q - coin_value(pay_coin);
               if (credit_d == '0) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake outputs follow the next state so they appear together with
      // the state change and the next change coin follows without a gap.
      vend_valid_d = (state_d == S_VEND);
      chg_valid_d  = (state_d == S_CHANGE);
      chg_coin_d   = chg_valid_d ? greedy_coin(credit_d) : 3'b000;
      busy_d       = vend_valid_d | chg_valid_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         credit_q      <= '0;
         tmo_q         <= '0;
         vend_item_q   <= 2'd0;
         vend_valid_q  <= 1'b0;
         chg_valid_q   <= 1'b0;
         chg_coin_q    <= 3'b000;
         coin_reject_q <= 1'b0;
         sel_short_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         tmo_q         <= tmo_d;
         vend_item_q   <= vend_item_d;
         vend_valid_q  <= vend_valid_d;
         chg_valid_q   <= chg_valid_d;
         chg_coin_q    <= chg_coin_d;
         coin_reject_q <= coin_reject_d;
         sel_short_q   <= sel_short_d;
         busy_q        <= busy_d;
      end
   end

   assign vend_valid  = vend_valid_q;
   assign vend_item   = vend_item_q;
   assign chg_valid   = chg_valid_q;
   assign chg_coin    = chg_coin_q;
   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;
   assign sel_short   = sel_short_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire
